ltc2600_channel_scheduler: RTL
==============================

# ltc2600_channel_scheduler

Sequencer placed in front of the LTC2600 serial write engine on the control board. It holds one shadow value and one pending flag per DAC channel, picks pending channels round-robin and issues one command at a time through the engine's `send_new_cmd`/`write_complete` handshake. Host (AXI register block) writes therefore never stall and never collide on the DAC bus.

## Interface
- `NUM_CH`, 8: number of DAC channels; legal range 1..8.
- `DATA_WIDTH`, 16: DAC code width; must match the write engine.
- `TIMEOUT_CYCLES`, 64: watchdog limit in WAIT; used only with `LTC2600_SCHED_TIMEOUT_EN`.
- `clk`  in  1  system clock, 50 MHz, shared with the write engine.
- `rst`  in  1  reset, asynchronous, active-high.
- `ch_wr_en`  in  1  one-cycle host write strobe.
- `ch_wr_addr`  in  $clog2(NUM_CH) (min 1)  target channel.
- `ch_wr_data`  in  DATA_WIDTH  new code.
- `ch_wr_update`  in  1  1: issue write-and-update-N; 0: issue write-N only.
- `update_all_req`  in  1  one-cycle strobe requesting update of all DAC registers.
- `err_clr`  in  1  clears `timeout_err`.
- `send_new_cmd`  out  1  to engine; rising edge starts a transfer.
- `command`  out  4  to engine.
- `address`  out  4  to engine.
- `data`  out  DATA_WIDTH  to engine.
- `write_complete`  in  1  from engine; one-cycle pulse.
- `pending`  out  NUM_CH  per-channel pending flags.
- `busy`  out  1  high in ISSUE or WAIT.
- `done`  out  1  one-cycle pulse per finished command.
- `timeout_err`  out  1  sticky watchdog flag; constant 0 without the macro.

## Operation
- Reset values: all outputs 0, except `command` = NOP (4'b1111) and `address` = 0. Shadows, pending flags and the update-all flag are cleared. The round-robin pointer is set to NUM_CH-1, so channel 0 has first priority.
- Host write: latches `ch_wr_data` and `ch_wr_update` into channel `ch_wr_addr` and sets its pending flag.
  - Writes to a pending channel overwrite it; the latest value wins.
  - Writes with address ≥ NUM_CH are ignored.
- `update_all_req` sets the update-all flag. Repeated strobes coalesce into one request.
- States:
  - IDLE → ISSUE when any channel is pending. Grant goes to the first pending channel after the pointer, modulo NUM_CH. On the transition:
    - latch `command` = 4'b0011 if update bit is 1, else 4'b0000;
    - latch `address` = channel index and `data` = shadow;
    - clear that pending flag and set the pointer to the granted channel.
  - IDLE → ISSUE when no channel is pending and the update-all flag is set. Latch `command` = 4'b0001, `address` = 4'hF, `data` = 0, and clear the flag. Update-all therefore always follows all queued writes.
  - ISSUE → WAIT unconditionally. `send_new_cmd` is 1 during ISSUE only.
  - WAIT → IDLE on `write_complete`. `done` pulses in the following cycle.
- Simultaneous host write and grant to the same channel: the grant carries the old shadow value. The pending flag ends set with the new value, because set wins over clear.
- `command`, `address` and `data` stay stable from ISSUE until the next grant.

## Timing
- Host write in cycle t: `pending` is visible at t+1. If idle, the grant happens at t+1 and `send_new_cmd` is high at t+2.
- `send_new_cmd` is high for exactly 1 cycle, with at least 1 low cycle between pulses. This is guaranteed by WAIT plus the IDLE cycle.
- Engine transfer is about 26 cycles. Back-to-back commands are separated by the engine latency plus 2 cycles.
- `write_complete` outside WAIT is ignored.
- Reset mid-transfer aborts immediately and all queued requests are lost. `rst` must also drive the engine's reset (inverted at top level) so both blocks restart together.

## Configuration
- `LTC2600_SCHED_TIMEOUT_EN` defined:
  - a counter runs in WAIT;
  - reaching TIMEOUT_CYCLES without `write_complete` sets `timeout_err`, forces WAIT → IDLE, and pulses no `done`;
  - the aborted channel's pending flag is not restored;
  - `err_clr` clears `timeout_err`; if it coincides with a new timeout, the set wins.
- Not defined: no counter, WAIT waits indefinitely, and `timeout_err` is tied to 0.

## Structure
- `ltc2600_pkg` holds:
  - command codes: `CMD_WRITE_N` = 0000, `CMD_UPDATE_N` = 0001, `CMD_WRITE_UPDATE_ALL` = 0010, `CMD_WRITE_UPDATE_N` = 0011, `CMD_POWER_DOWN_N` = 0100, `CMD_NOP` = 1111;
  - `ADDR_ALL` = 4'hF;
  - the scheduler state enum.
- Sub-module `rr_arbiter`: parameter N; inputs request vector and last-grant index; outputs grant index and valid. It is purely combinational.

## Test plan
- Single write ch3 = 16'hABCD, update = 1 → one `send_new_cmd` pulse at t+2 with command 0011, address 3, data ABCD; `done` one cycle after `write_complete`.
- Writes to ch0, ch5, ch2 in one idle stretch → issue order 0, 2, 5; pointer wrap verified by a follow-up ch1 write, issued before ch0 is re-requested.
- Three writes to ch4 (1, 2, 3) while ch4 is queued behind an in-flight ch1 → exactly one ch4 command, carrying data 3.
- `update_all_req` with ch6 pending → ch6 write first, then command 0001, address F; two strobes give one update.
- Assert `rst` mid-WAIT with ch1 pending → all outputs at reset values next cycle, `pending` = 0, no `done`.
- With macro defined, engine never returns `write_complete` → `timeout_err` = 1 after 64 WAIT cycles, block back in IDLE; `err_clr` clears it.

Source files
------------

// File: rtl/ltc2600_pkg.sv
// ltc2600_pkg
//   Shared definitions for the LTC2600 channel scheduler: DAC command codes,
//   the broadcast address and the scheduler state encoding.
package ltc2600_pkg;

  localparam logic [3:0] CMD_WRITE_N          = 4'b0000;
  localparam logic [3:0] CMD_UPDATE_N         = 4'b0001;
  localparam logic [3:0] CMD_WRITE_UPDATE_ALL = 4'b0010;
  localparam logic [3:0] CMD_WRITE_UPDATE_N   = 4'b0011;
  localparam logic [3:0] CMD_POWER_DOWN_N     = 4'b0100;
  localparam logic [3:0] CMD_NOP              = 4'b1111;

  localparam logic [3:0] ADDR_ALL = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin picker. Searches the request vector starting
//   one position after the last grant and wrapping modulo N.
//   Ports:
//     req   in  N   request vector
//     last  in  LW  index of the previous grant
//     grant out LW  index of the selected request (0 when none)
//     valid out 1   at least one request is present
module rr_arbiter #(
  parameter int N = 8,
  localparam int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [LW-1:0] grant,
  output logic          valid
);

  always_comb begin
    int          idx;
    logic [N-1:0] sh;
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    sh    = '0;
    // Offset 1 is checked first, so the channel right after the last grant
    // has the highest priority; offset N comes back round to `last` itself.
    for (int off = 1; off <= N; off++) begin
      idx = (int'(last) + off) % N;
      sh  = req >> idx;
      if (!valid && sh[0]) begin
        valid = 1'b1;
        grant = LW'(idx);
      end
    end
  end

endmodule

// File: rtl/ltc2600_channel_scheduler.sv
// ltc2600_channel_scheduler
//   Holds one shadow code and one pending flag per DAC channel and feeds the
//   LTC2600 write engine one command at a time, round-robin across channels.
//   A coalesced update-all request is issued only once no channel is pending.
//
//   Handshake with the engine: send_new_cmd is high for the single ISSUE
//   cycle while command/address/data are already valid; the block then sits
//   in WAIT until the engine returns a one-cycle write_complete, and pulses
//   done in the cycle after. command/address/data hold until the next grant.
//
//   Optional feature macro: LTC2600_SCHED_TIMEOUT_EN adds a WAIT watchdog
//   that sets the sticky timeout_err after TIMEOUT_CYCLES and returns to IDLE.
//
//   Ports:
//     clk, rst                 clock, async active-high reset
//     ch_wr_en/addr/data/update host write into a channel shadow
//     update_all_req           request a broadcast update
//     err_clr                  clears timeout_err
//     send_new_cmd, command, address, data   to the write engine
//     write_complete           from the write engine
//     pending                  per-channel pending flags
//     busy                     high in ISSUE or WAIT
//     done                     one-cycle pulse per completed command
//     timeout_err              sticky watchdog flag
//     state_dbg                current scheduler state
module ltc2600_channel_scheduler
  import ltc2600_pkg::*;
#(
  parameter int NUM_CH         = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int AW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ch_wr_en,
  input  logic [AW-1:0]         ch_wr_addr,
  input  logic [DATA_WIDTH-1:0] ch_wr_data,
  input  logic                  ch_wr_update,
  input  logic                  update_all_req,
  input  logic                  err_clr,
  output logic                  send_new_cmd,
  output logic [3:0]            command,
  output logic [3:0]            address,
  output logic [DATA_WIDTH-1:0] data,
  input  logic                  write_complete,
  output logic [NUM_CH-1:0]     pending,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  output sched_state_t          state_dbg
);

  sched_state_t          state;
  logic [AW-1:0]         ptr;
  logic                  upd_all;
  logic [DATA_WIDTH-1:0] shadow_data [NUM_CH];
  logic [NUM_CH-1:0]     shadow_upd;

  logic [AW-1:0]         gnt_idx;
  logic                  gnt_valid;
  logic                  wr_ok;

  assign state_dbg = state;
  assign wr_ok     = ch_wr_en && (int'(ch_wr_addr) < NUM_CH);

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .req   (pending),
    .last  (ptr),
    .grant (gnt_idx),
    .valid (gnt_valid)
  );

`ifdef LTC2600_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_cnt;
`else
  logic unused_cfg;
  assign unused_cfg  = err_clr ^ (TIMEOUT_CYCLES > 0);
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      ptr          <= AW'(NUM_CH - 1);
      upd_all      <= 1'b0;
      pending      <= '0;
      shadow_upd   <= '0;
      for (int i = 0; i < NUM_CH; i++) shadow_data[i] <= '0;
      send_new_cmd <= 1'b0;
      command      <= CMD_NOP;
      address      <= '0;
      data         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef LTC2600_SCHED_TIMEOUT_EN
      wd_cnt       <= '0;
      timeout_err  <= 1'b0;
`endif
    end else begin
      send_new_cmd <= 1'b0;
      done         <= 1'b0;
`ifdef LTC2600_SCHED_TIMEOUT_EN
      // Placed before the FSM so a timeout in the same cycle overrides it.
      if (err_clr) timeout_err <= 1'b0;
`endif

      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            command          <= shadow_upd[gnt_idx] ? CMD_WRITE_UPDATE_N : CMD_WRITE_N;
            address          <= {{(4-AW){1'b0}}, gnt_idx};
            data             <= shadow_data[gnt_idx];
            pending[gnt_idx] <= 1'b0;
            ptr              <= gnt_idx;
            send_new_cmd     <= 1'b1;
            busy             <= 1'b1;
            state            <= ST_ISSUE;
          end else if (upd_all) begin
            command      <= CMD_UPDATE_N;
            address      <= ADDR_ALL;
            data         <= '0;
            upd_all      <= 1'b0;
            send_new_cmd <= 1'b1;
            busy         <= 1'b1;
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
`ifdef LTC2600_SCHED_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end
        ST_WAIT: begin
          if (write_complete) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
`ifdef LTC2600_SCHED_TIMEOUT_EN
          else if (wd_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + TW'(1);
          end
`endif
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Host write comes after the grant so a same-cycle set beats the clear;
      // the grant above already captured the previous shadow value.
      if (wr_ok) begin
        shadow_data[ch_wr_addr] <= ch_wr_data;
        shadow_upd[ch_wr_addr]  <= ch_wr_update;
        pending[ch_wr_addr]     <= 1'b1;
      end
      if (update_all_req) upd_all <= 1'b1;
    end
  end

endmodule
